orientation_histogram: RTL
==========================

ORIENTATION_HISTOGRAM -- requirements
Module: orientation_histogram

Interface
REQ-001 Parameter SAMPLES, default 256, range 1..256: samples accepted per keypoint window.
REQ-002 iclk  input  1  processing clock, the same domain as the read side of the orientation FIFO; all logic rises on posedge iclk.
REQ-003 ireset  input  1  synchronous, active-low reset, sampled on posedge iclk.
REQ-004 ivalid  input  1  idata holds a valid sample this cycle.
REQ-005 idata  input  16  [15:10] orientation bin index (0..35); [9:0] unsigned gradient magnitude.
REQ-006 iready  output  1  block accepts a sample this cycle.
REQ-007 ovalid  output  1  one-cycle pulse: obin and omag hold a result.
REQ-008 obin  output  6  dominant orientation bin, 0..35.
REQ-009 omag  output  18  accumulated magnitude of the dominant bin.
REQ-010 obad_bin  output  1  sticky flag: a sample with bin index >= 36 was accepted.
REQ-011 odrop  output  1  one-cycle pulse: ivalid=1 while iready=0, so the sample is discarded.

Function
REQ-012 Histogram: 36 registers of 18 bits; acc[b] is the magnitude sum for bin b.
REQ-013 FSM states: ACCUM, SCAN, EMIT; iready=1 only in ACCUM.
REQ-014 Acceptance: a sample is accepted when ivalid=1 and iready=1 on the same edge.
- Accepted sample with bin < 36: acc[bin] += magnitude in that cycle, as a single-cycle read-modify-write.
- Back-to-back samples to the same bin accumulate correctly, with no hazard.
REQ-015 Sample with bin >= 36:
- counts toward SAMPLES;
- does not change any acc;
- sets obad_bin.
REQ-016 Sample counter: 9 bits, increments per accepted sample. When the accepted sample is number SAMPLES, the FSM moves ACCUM->SCAN on the next edge, and that sample is already included in acc.
REQ-017 Width: no overflow is possible, since 256*1023 < 2^18; no saturation logic.
REQ-018 SCAN lasts exactly 36 cycles, index i=0..35 ascending:
- at i=0: best_bin=0, best_mag=acc[0];
- at i>0: best is replaced only if acc[i] > best_mag (strict).
- Ties therefore resolve to the lowest bin index.
REQ-019 After i=35 the FSM enters EMIT for exactly 1 cycle. During EMIT:
- ovalid=1;
- obin/omag = best;
- all acc and the sample counter clear on the edge leaving EMIT;
- FSM returns to ACCUM.
REQ-020 Latency: ovalid asserts 37 cycles after the edge that accepts the final sample; iready is low for 37 cycles per window.
REQ-021 obin/omag hold their value after EMIT until the next EMIT.
REQ-022 All-zero histogram produces obin=0, omag=0.
REQ-023 odrop is combinational on ivalid & !iready; a dropped sample affects no state other than odrop.
REQ-024 obad_bin clears only on reset.

Reset
REQ-025 When ireset=0 at a posedge:
- FSM=ACCUM, counter=0, all acc=0;
- ovalid=0, obin=0, omag=0, obad_bin=0;
- iready=0 while ireset=0, and odrop=0 while ireset=0.
REQ-026 Reset asserted mid-ACCUM, SCAN or EMIT aborts the window: no ovalid is produced, and the first cycle after release is ACCUM with an empty histogram.

Verification
REQ-027 SAMPLES=256, 256 samples of bin 7 mag 1023 back-to-back -> 37 cycles later ovalid=1, obin=7, omag=261888.
REQ-028 SAMPLES=4, samples (3,100),(5,100),(3,1),(5,1) -> obin=3, omag=101 (tie broken to lower bin).
REQ-029 SAMPLES=4, samples (40,500),(2,10),(2,10),(2,10) -> obin=2, omag=30, obad_bin=1 and stays 1 in the next window.
REQ-030 ivalid held high across SCAN/EMIT -> odrop=1 for 37 cycles, histogram of the next window unaffected, second window result correct.
REQ-031 ireset=0 for 1 cycle during SCAN -> no ovalid pulse; a following 4-sample window (0,0)x4 gives obin=0, omag=0.
REQ-032 Gapped input (ivalid toggling every other cycle) -> same result as back-to-back input for an identical sample set.

Source files
------------

// File: rtl/orientation_histogram.sv
// Accumulates gradient magnitudes into 36 orientation bins over a window of
// SAMPLES inputs, then scans for the dominant bin and emits it for one cycle.
module orientation_histogram #(
    parameter int SAMPLES = 256
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        ivalid,
    input  logic [15:0] idata,
    output logic        iready,
    output logic        ovalid,
    output logic [5:0]  obin,
    output logic [17:0] omag,
    output logic        obad_bin,
    output logic        odrop
);

    localparam int NBINS = 36;

    typedef enum logic [1:0] {ACCUM, SCAN, EMIT} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  count_reg;
    logic [5:0]  scan_idx_reg;
    logic [5:0]  best_bin_reg, best_bin_next;
    logic [17:0] best_mag_reg, best_mag_next;
    logic [5:0]  obin_reg;
    logic [17:0] omag_reg;
    logic        obad_bin_reg;
    logic [17:0] acc_reg [NBINS];
    logic [NBINS-1:0] hit;

    logic [5:0]  in_bin;
    logic [9:0]  in_mag;
    logic        accept;
    logic        last_sample;
    logic [17:0] scan_rd;

    assign in_bin      = idata[15:10];
    assign in_mag      = idata[9:0];
    assign iready      = ireset && (state_reg == ACCUM);
    assign odrop       = ireset && ivalid && !iready;
    assign ovalid      = ireset && (state_reg == EMIT);
    assign accept      = ivalid && iready;
    assign last_sample = accept && (count_reg == 9'(SAMPLES - 1));
    assign scan_rd     = acc_reg[scan_idx_reg];
    assign obin        = obin_reg;
    assign omag        = omag_reg;
    assign obad_bin    = obad_bin_reg;

    // One-hot bin select; out-of-range indices match no bin and are simply counted.
    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_hit
            assign hit[gi] = accept && (in_bin == 6'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        best_bin_next = best_bin_reg;
        best_mag_next = best_mag_reg;
        case (state_reg)
            ACCUM: begin
                if (last_sample) state_next = SCAN;
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (scan_idx_reg == 6'd0 || scan_rd > best_mag_reg) begin
                    best_bin_next = scan_idx_reg;
                    best_mag_next = scan_rd;
                end
                if (scan_idx_reg == 6'(NBINS - 1)) state_next = EMIT;
            end
            EMIT: begin
                state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state_reg    <= ACCUM;
            count_reg    <= '0;
            scan_idx_reg <= '0;
            best_bin_reg <= '0;
            best_mag_reg <= '0;
            obin_reg     <= '0;
            omag_reg     <= '0;
            obad_bin_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            best_bin_reg <= best_bin_next;
            best_mag_reg <= best_mag_next;
            scan_idx_reg <= (state_reg == SCAN) ? scan_idx_reg + 6'd1 : 6'd0;
            if (state_reg == EMIT)
                count_reg <= '0;
            else if (accept)
                count_reg <= count_reg + 9'd1;
            // Result is latched with the final comparison so it is valid throughout EMIT.
            if (state_reg == SCAN && scan_idx_reg == 6'(NBINS - 1)) begin
                obin_reg <= best_bin_next;
                omag_reg <= best_mag_next;
            end
            if (accept && in_bin >= 6'(NBINS))
                obad_bin_reg <= 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        for (int b = 0; b < NBINS; b++) begin
            if (!ireset || state_reg == EMIT)
                acc_reg[b] <= '0;
            else if (hit[b])
                acc_reg[b] <= acc_reg[b] + 18'(in_mag);
        end
    end

endmodule
